clint_mh: RTL

- Multi-hart core-local interruptor.
- Holds one shared 64-bit mtime counter, advanced by a programmable prescaler.
- Holds one 64-bit mtimecmp and one msip bit per hart.
- Produces per-hart timer and software interrupt lines to each hart's CSR unit.
- Slave on the core's simple req/we bus, with a registered one-cycle read/ack response.

---
 rtl/clint_pkg.sv | 30 +++
 rtl/clint_mtime.sv | 56 +++++
 rtl/clint_mh.sv | 127 ++++++++++++
 3 files changed

// File: rtl/clint_pkg.sv
// ============================================================================
// Module      : clint_pkg
// Description : Shared constants and address helpers for the clint_mh CLINT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clint_pkg;

    localparam int XLEN = 32;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;

    localparam int MSIP_STRIDE     = 4;
    localparam int MTIMECMP_STRIDE = 8;

    function automatic logic [15:0] msip_addr(input int h);
        return MSIP_BASE + 16'(MSIP_STRIDE * h);
    endfunction

    function automatic logic [15:0] mtimecmp_addr(input int h);
        return MTIMECMP_BASE + 16'(MTIMECMP_STRIDE * h);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clint_mtime.sv
// ============================================================================
// Module      : clint_mtime
// Description : Prescaler and shared 64-bit mtime counter with half-word writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clint_mtime #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_mtime,
    output logic [63:0] o_mtime_nxt
);

    localparam logic [15:0] C_PRE_LAST = 16'(TICK_DIV - 1);

    logic [15:0] r_pre;
    logic [63:0] r_mtime;
    logic [15:0] w_pre_nxt;
    logic [63:0] w_mtime_nxt;

    // A software write wins over a coincident tick and restarts the prescaler.
    always_comb begin
        w_pre_nxt   = r_pre + 16'd1;
        w_mtime_nxt = r_mtime;
        if (i_wr_lo || i_wr_hi) begin
            w_pre_nxt = '0;
            if (i_wr_lo) w_mtime_nxt[31:0]  = i_wdata;
            if (i_wr_hi) w_mtime_nxt[63:32] = i_wdata;
        end else if (r_pre == C_PRE_LAST) begin
            w_pre_nxt   = '0;
            w_mtime_nxt = r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pre   <= '0;
            r_mtime <= '0;
        end else begin
            r_pre   <= w_pre_nxt;
            r_mtime <= w_mtime_nxt;
        end
    end

    assign o_mtime     = r_mtime;
    assign o_mtime_nxt = w_mtime_nxt;

endmodule

`default_nettype wire

// File: rtl/clint_mh.sv
// ============================================================================
// Module      : clint_mh
// Description : Multi-hart core-local interruptor (mtime, mtimecmp, msip).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clint_mh
    import clint_pkg::*;
#(
    parameter int NUM_HARTS = 2,
    parameter int TICK_DIV  = 1,
    parameter int ADDR_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [XLEN-1:0]      addr_i,
    input  logic [XLEN-1:0]      data_i,
    output logic [XLEN-1:0]      data_o,
    output logic                 ack_o,
    output logic [NUM_HARTS-1:0] timer_irq_o,
    output logic [NUM_HARTS-1:0] software_irq_o
);

    logic [ADDR_W-1:0]    w_off;
    logic                 w_wr;
    logic                 w_mt_lo_hit;
    logic                 w_mt_hi_hit;
    logic [63:0]          w_mtime;
    logic [63:0]          w_mtime_nxt;
    logic [NUM_HARTS-1:0] w_msip_hit;
    logic [NUM_HARTS-1:0] w_cmp_lo_hit;
    logic [NUM_HARTS-1:0] w_cmp_hi_hit;
    logic [63:0]          w_cmp [NUM_HARTS];
    logic [XLEN-1:0]      w_rdata;
    logic                 r_ack;
    logic [XLEN-1:0]      r_data;

    assign w_off       = addr_i[ADDR_W-1:0];
    assign w_wr        = req_i && we_i;
    assign w_mt_lo_hit = (w_off == ADDR_W'(MTIME_LO));
    assign w_mt_hi_hit = (w_off == ADDR_W'(MTIME_HI));

    generate
        if (ADDR_W < XLEN) begin : g_addr_hi
            logic w_unused_addr;
            assign w_unused_addr = ^addr_i[XLEN-1:ADDR_W];
        end
    endgenerate

    clint_mtime #(
        .TICK_DIV (TICK_DIV)
    ) u_mtime (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_wr_lo     (w_wr && w_mt_lo_hit),
        .i_wr_hi     (w_wr && w_mt_hi_hit),
        .i_wdata     (data_i),
        .o_mtime     (w_mtime),
        .o_mtime_nxt (w_mtime_nxt)
    );

    generate
        for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
            logic        r_msip;
            logic        r_tirq;
            logic [63:0] r_cmp;
            logic [63:0] w_cmp_nxt;

            assign w_msip_hit[h]   = (w_off == ADDR_W'(msip_addr(h)));
            assign w_cmp_lo_hit[h] = (w_off == ADDR_W'(mtimecmp_addr(h)));
            assign w_cmp_hi_hit[h] = (w_off == ADDR_W'(mtimecmp_addr(h) + 16'd4));

            always_comb begin
                w_cmp_nxt = r_cmp;
                if (w_wr && w_cmp_lo_hit[h]) w_cmp_nxt[31:0]  = data_i;
                if (w_wr && w_cmp_hi_hit[h]) w_cmp_nxt[63:32] = data_i;
            end

            // Compare against the values this edge is about to commit.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_msip <= 1'b0;
                    r_tirq <= 1'b0;
                    r_cmp  <= '1;
                end else begin
                    if (w_wr && w_msip_hit[h]) r_msip <= data_i[0];
                    r_cmp  <= w_cmp_nxt;
                    r_tirq <= (w_mtime_nxt >= w_cmp_nxt);
                end
            end

            assign w_cmp[h]          = r_cmp;
            assign software_irq_o[h] = r_msip;
            assign timer_irq_o[h]    = r_tirq;
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        if (w_mt_lo_hit) w_rdata = w_mtime[31:0];
        if (w_mt_hi_hit) w_rdata = w_mtime[63:32];
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_msip_hit[h])   w_rdata = {{(XLEN-1){1'b0}}, software_irq_o[h]};
            if (w_cmp_lo_hit[h]) w_rdata = w_cmp[h][31:0];
            if (w_cmp_hi_hit[h]) w_rdata = w_cmp[h][63:32];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack  <= 1'b0;
            r_data <= '0;
        end else begin
            r_ack  <= req_i;
            r_data <= (req_i && !we_i) ? w_rdata : '0;
        end
    end

    assign ack_o  = r_ack;
    assign data_o = r_data;

endmodule

`default_nettype wire
